// File: rtl/dotn_seq.sv
// Sequential signed fixed-point N-element dot product on one shift-add multiplier.
// Optional DOTN_SATURATE_EN: wide accumulator with a final clamp instead of wrap-around.
module dotn_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N     = 4,
    parameter int LGN   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 acc_en,
    input  logic [N*WIDTH-1:0]   v1,
    input  logic [N*WIDTH-1:0]   v2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
`ifdef DOTN_SATURATE_EN
    localparam int AW = WIDTH + LGN + 1;
`else
    localparam int AW = WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_t;

    state_t state, state_nx;

    logic [N*WIDTH-1:0] v1_q, v2_q;
    logic [AW-1:0]      acc_q;
    logic [LGN-1:0]     k_q;
    logic [LGN-1:0]     k_nx;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      prod_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;

    logic               last_bit;
    logic               last_elem;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      prod_nx;
    logic [WIDTH-1:0]   psl;
    logic [AW-1:0]      psl_ext;
    logic [AW-1:0]      acc_sum;
    logic [WIDTH-1:0]   final_val;
    logic [WIDTH-1:0]   nx1, nx2;
    logic               unused_bits;

    assign busy   = (state != IDLE);
    assign done   = done_q;
    assign result = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = MUL;
            MUL:     if (last_bit) state_nx = ACC;
            ACC:     state_nx = last_elem ? IDLE : MUL;
            default: state_nx = IDLE;
        endcase
    end

    // The multiplier MSB carries negative weight in two's complement.
    always_comb begin
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        last_elem = (k_q == LGN'(N - 1));
        k_nx      = k_q + 1'b1;
        pp        = mplier_q[0] ? mcand_q : '0;
        prod_nx   = last_bit ? (prod_q - pp) : (prod_q + pp);
        psl       = prod_q[FRAC+WIDTH-1:FRAC];
        psl_ext   = AW'($signed(psl));
        acc_sum   = acc_q + psl_ext;
        nx1       = v1_q[k_nx*WIDTH +: WIDTH];
        nx2       = v2_q[k_nx*WIDTH +: WIDTH];
`ifdef DOTN_SATURATE_EN
        if ((&acc_sum[AW-1:WIDTH-1]) || ~(|acc_sum[AW-1:WIDTH-1]))
            final_val = acc_sum[WIDTH-1:0];
        else
            final_val = {acc_sum[AW-1], {(WIDTH-1){~acc_sum[AW-1]}}};
`else
        final_val = acc_sum;
`endif
    end

    assign unused_bits = ^{prod_q[FRAC-1:0], prod_q[PW-1:FRAC+WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q     <= '0;
            v2_q     <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        v1_q     <= v1;
                        v2_q     <= v2;
                        acc_q    <= acc_en ? AW'($signed(result_q)) : '0;
                        k_q      <= '0;
                        cnt_q    <= '0;
                        mcand_q  <= PW'($signed(v1[WIDTH-1:0]));
                        mplier_q <= v2[WIDTH-1:0];
                        prod_q   <= '0;
                    end
                end
                MUL: begin
                    prod_q   <= prod_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                ACC: begin
                    acc_q <= acc_sum;
                    if (last_elem) begin
                        result_q <= final_val;
                        done_q   <= 1'b1;
                    end else begin
                        k_q      <= k_nx;
                        cnt_q    <= '0;
                        prod_q   <= '0;
                        mcand_q  <= PW'($signed(nx1));
                        mplier_q <= nx2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dotn_seq.sv
// Directed bench for dotn_seq at default parameters (Q8.8, N=4).
module tb_dotn_seq;

    localparam int W = 16;
    localparam int N = 4;
    localparam int LAT = 68;

    logic             clk;
    logic             reset;
    logic             start;
    logic             acc_en;
    logic [N*W-1:0]   v1;
    logic [N*W-1:0]   v2;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;

    int checks;
    int failures;

    dotn_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .acc_en (acc_en),
        .v1     (v1),
        .v2     (v2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [N*W-1:0] VA   = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    localparam logic [N*W-1:0] ONES = {16'h0100, 16'h0100, 16'h0100, 16'h0100};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [N*W-1:0] a,
                          input logic [N*W-1:0] b, input logic acc,
                          input logic [W-1:0] exp);
        int cyc;
        @(negedge clk);
        v1 = a;
        v2 = b;
        acc_en = acc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_en = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check({tag, "_res"}, 32'(result), 32'(exp));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int dcyc;
        int d1;
        int d2;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        acc_en = 1'b0;
        v1 = '0;
        v2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("sum10", VA, ONES, 1'b0, 16'h0A00);
        run_op("accum", {48'h0, 16'h0100}, {48'h0, 16'h0100}, 1'b1, 16'h0B00);
        run_op("neg", {48'h0, 16'hFE80}, {48'h0, 16'h0200}, 1'b0, 16'hFD00);
        run_op("floor", {48'h0, 16'hFFFF}, {48'h0, 16'h0001}, 1'b0, 16'hFFFF);
        run_op("minsq", {48'h0, 16'h8000}, {48'h0, 16'h8000}, 1'b0, 16'h0000);
        run_op("mixed", {16'h0040, 16'h0000, 16'hFF00, 16'h0180},
               {16'h0400, 16'h0000, 16'h0300, 16'h0200}, 1'b0, 16'h0100);
`ifdef DOTN_SATURATE_EN
        run_op("ovf", {4{16'h6400}}, ONES, 1'b0, 16'h7FFF);
`else
        run_op("ovf", {4{16'h6400}}, ONES, 1'b0, 16'h9000);
`endif

        // Restart attempt and input change while busy.
        @(negedge clk);
        v1 = VA;
        v2 = ONES;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        dcyc = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                start = 1'b1;
                v1 = {4{16'h7FFF}};
                v2 = {4{16'h7FFF}};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                dcyc = c;
            end
        end
        check("mid_ndone", 32'(ndone), 32'd1);
        check("mid_lat", 32'(dcyc), 32'(LAT));
        check("mid_res", 32'(result), 32'h0A00);

        // Reset in the middle of an operation.
        @(negedge clk);
        v1 = {4{16'h0200}};
        v2 = ONES;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", VA, ONES, 1'b0, 16'h0A00);

        // Start held high: back-to-back operations.
        @(negedge clk);
        v1 = VA;
        v2 = ONES;
        start = 1'b1;
        @(posedge clk);
        #1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 300 && d2 == 0; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
        end
        start = 1'b0;
        check("b2b_first", 32'(d1), 32'(LAT));
        check("b2b_second", 32'(d2), 32'(2 * LAT + 1));
        check("b2b_res", 32'(result), 32'h0A00);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_stop", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
